// File: rtl/lstm_neuron_mac_if.sv
`default_nettype none
// ============================================================================
// Module      : lstm_neuron_mac_if
// Description : Handshake bundle for the LSTM neuron MAC stage.
//               Input side : in_valid/in_ready carrying x, w, bias, in_last.
//               Output side: z_valid/z_ready carrying z_value.
//               master = producer of pairs / consumer of z (upstream + activation)
//               slave  = the MAC stage itself
// Revision    : 1.0 - initial release
// ============================================================================
interface lstm_neuron_mac_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] w;
  logic [DATA_W-1:0] bias;
  logic              in_last;
  logic              z_valid;
  logic              z_ready;
  logic [DATA_W-1:0] z_value;

  modport master (
    output in_valid, x, w, bias, in_last, z_ready,
    input  in_ready, z_valid, z_value
  );

  modport slave (
    input  in_valid, x, w, bias, in_last, z_ready,
    output in_ready, z_valid, z_value
  );
endinterface
`default_nettype wire

// File: rtl/lstm_neuron_mac.sv
`default_nettype none
// ============================================================================
// Module      : lstm_neuron_mac
// Description : Per-neuron multiply-accumulate ahead of the sigmoid/tanh
//               activation. Accumulates signed Q4.4 x*w products at full
//               precision (saturating), adds a Q4.4 bias on the first beat and
//               requantizes the sum to a signed Q4.4 z_value.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-low reset
//               bus  - lstm_neuron_mac_if.slave (input pairs + z output)
// Revision    : 1.0 - initial release
// ============================================================================
module lstm_neuron_mac #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 4,
  parameter int ACC_W  = 20
) (
  input  wire logic             clk,
  input  wire logic             rst,
  lstm_neuron_mac_if.slave      bus
);

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  localparam logic signed [ACC_W-1:0]  c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [DATA_W-1:0]        c_z_max   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]        c_z_min   = {1'b1, {(DATA_W-1){1'b0}}};

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic                       r_first;
  logic signed [ACC_W-1:0]    r_acc;
  logic                       r_z_valid;
  logic [DATA_W-1:0]          r_z_value;

  logic                       w_accept;
  logic                       w_z_hs;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_bias_ext;
  logic signed [ACC_W-1:0]    w_base;
  logic signed [ACC_W:0]      w_sum_ext;
  logic signed [ACC_W-1:0]    w_sum;
  logic signed [ACC_W-1:0]    w_shift;
  logic [DATA_W-1:0]          w_quant;

  // in_ready depends only on registered state, never on z_ready.
  assign bus.in_ready = (r_state == ST_ACC);
  assign bus.z_valid  = r_z_valid;
  assign bus.z_value  = r_z_value;

  assign w_accept = bus.in_valid && (r_state == ST_ACC);
  assign w_z_hs   = r_z_valid && bus.z_ready;

  assign w_prod = $signed(bus.x) * $signed(bus.w);

  // Bias is Q4.4; shifting left by FRAC_W aligns it to the Q.8 product scale.
  assign w_bias_ext = {{(ACC_W-DATA_W-FRAC_W){bus.bias[DATA_W-1]}}, bus.bias, {FRAC_W{1'b0}}};
  assign w_base     = r_first ? w_bias_ext : r_acc;

  // One guard bit catches overflow of the ACC_W-bit running sum.
  assign w_sum_ext = {w_base[ACC_W-1], w_base}
                   + {{(ACC_W+1-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};

  always_comb begin
    w_sum = w_sum_ext[ACC_W-1:0];
    if (w_sum_ext[ACC_W] != w_sum_ext[ACC_W-1]) begin
      w_sum = w_sum_ext[ACC_W] ? c_acc_min : c_acc_max;
    end
  end

  // Floor requantization: arithmetic shift drops the extra fraction bits,
  // then clamp if the integer part no longer fits in DATA_W bits.
  assign w_shift = w_sum >>> FRAC_W;

  always_comb begin
    w_quant = w_shift[DATA_W-1:0];
    if (!((&w_shift[ACC_W-1:DATA_W-1]) || !(|w_shift[ACC_W-1:DATA_W-1]))) begin
      w_quant = w_shift[ACC_W-1] ? c_z_min : c_z_max;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACC:  if (w_accept && bus.in_last) w_state_nxt = ST_OUT;
      ST_OUT:  if (w_z_hs)                  w_state_nxt = ST_ACC;
      default: w_state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_first   <= 1'b1;
      r_acc     <= '0;
      r_z_valid <= 1'b0;
      r_z_value <= '0;
    end else begin
      if (w_accept) begin
        r_first <= 1'b0;
        if (bus.in_last) begin
          r_acc     <= '0;
          r_z_value <= w_quant;
          r_z_valid <= 1'b1;
        end else begin
          r_acc <= w_sum;
        end
      end else if (w_z_hs) begin
        r_z_valid <= 1'b0;
        r_first   <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lstm_neuron_mac.sv
`default_nettype none
// ============================================================================
// Module      : tb_lstm_neuron_mac
// Description : Self-checking bench for lstm_neuron_mac. Directed and random
//               vectors are compared with an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lstm_neuron_mac;

  logic clk;
  logic rst;

  lstm_neuron_mac_if #(.DATA_W(8)) bus_if ();

  lstm_neuron_mac #(
    .DATA_W(8),
    .FRAC_W(4),
    .ACC_W (20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] vx [64];
  logic [7:0] vw [64];

  // Reference: plain integer arithmetic with saturation to 20 bits signed.
  function automatic logic [7:0] model_z(input int n, input logic [7:0] b);
    int s;
    int q;
    s = int'($signed(b)) * 16;
    for (int i = 0; i < n; i++) begin
      s = s + int'($signed(vx[i])) * int'($signed(vw[i]));
      if (s > 524287)  s = 524287;
      if (s < -524288) s = -524288;
    end
    q = s >>> 4;
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    return q[7:0];
  endfunction

  // Drives an n-beat vector from vx/vw. Called right after posedge+#1.
  // Returns z_valid and z_value sampled just after the last-beat edge.
  task automatic drive_vec(input int n, input logic [7:0] b, input int gap_pct,
                           output logic zv, output logic [7:0] z);
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        bus_if.in_valid = 1'b0;
        bus_if.x        = 8'($urandom);
        bus_if.w        = 8'($urandom);
        @(posedge clk); #1;
      end
      bus_if.in_valid = 1'b1;
      bus_if.x        = vx[i];
      bus_if.w        = vw[i];
      bus_if.bias     = (i == 0) ? b : 8'($urandom);
      bus_if.in_last  = (i == n - 1);
      @(posedge clk); #1;
    end
    bus_if.in_valid = 1'b0;
    bus_if.in_last  = 1'b0;
    zv = bus_if.z_valid;
    z  = bus_if.z_value;
  endtask

  task automatic release_z(input int delay);
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
    end
    bus_if.z_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.z_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic zv;
    logic [7:0] z;
    // Power-on state while reset held.
    n_checks++;
    if (bus_if.z_valid !== 1'b0 || bus_if.z_value !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_por: z_valid=%b z_value=%h, want 0/00", bus_if.z_valid, bus_if.z_value);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus_if.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: in_ready=%b want 1", bus_if.in_ready);
    end
    // Leave a non-zero z_value behind: (0x30<<4 + 0x10*0x10)>>4 = 0x40.
    vx[0] = 8'h10; vw[0] = 8'h10;
    drive_vec(1, 8'h30, 0, zv, z);
    n_checks++;
    if (z !== 8'h40) begin
      n_fail++;
      $display("FAIL reset_pre: z_value=%h want 40", z);
    end
    release_z(0);
    // Two beats of a vector, then asynchronous reset between edges.
    vx[0] = 8'h40; vw[0] = 8'h40; vx[1] = 8'h40; vw[1] = 8'h40;
    for (int i = 0; i < 2; i++) begin
      bus_if.in_valid = 1'b1; bus_if.x = vx[i]; bus_if.w = vw[i];
      bus_if.bias = 8'h20; bus_if.in_last = 1'b0;
      @(posedge clk); #1;
    end
    bus_if.in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (bus_if.z_valid !== 1'b0 || bus_if.z_value !== 8'h00 || bus_if.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: z_valid=%b z_value=%h in_ready=%b want 0/00/1",
               bus_if.z_valid, bus_if.z_value, bus_if.in_ready);
    end
    #1 rst = 1'b1;
    @(posedge clk); #1;
    vx[0] = 8'h10; vw[0] = 8'h10;
    drive_vec(1, 8'h00, 0, zv, z);
    n_checks++;
    if (zv !== 1'b1 || z !== 8'h10) begin
      n_fail++;
      $display("FAIL reset_after: z_valid=%b z_value=%h want 1/10", zv, z);
    end
    release_z(0);
  endtask

  task automatic test_basic();
    logic zv;
    logic [7:0] z;
    vx[0] = 8'h10; vw[0] = 8'h20; vx[1] = 8'h10; vw[1] = 8'h10;
    drive_vec(2, 8'h08, 0, zv, z);
    n_checks++;
    if (zv !== 1'b1 || z !== 8'h38) begin
      n_fail++;
      $display("FAIL basic: z_valid=%b z_value=%h want 1/38", zv, z);
    end
    release_z(1);
  endtask

  task automatic test_truncation();
    logic zv;
    logic [7:0] z;
    vx[0] = 8'hF8; vw[0] = 8'h18;
    drive_vec(1, 8'h00, 0, zv, z);
    n_checks++;
    if (zv !== 1'b1 || z !== 8'hF4) begin
      n_fail++;
      $display("FAIL trunc_neg: z_valid=%b z_value=%h want 1/f4", zv, z);
    end
    release_z(0);
    vx[0] = 8'h01; vw[0] = 8'h01;
    drive_vec(1, 8'h00, 0, zv, z);
    n_checks++;
    if (zv !== 1'b1 || z !== 8'h00) begin
      n_fail++;
      $display("FAIL trunc_small: z_valid=%b z_value=%h want 1/00", zv, z);
    end
    release_z(0);
  endtask

  task automatic test_saturation();
    logic zv;
    logic [7:0] z;
    for (int i = 0; i < 4; i++) begin vx[i] = 8'h7F; vw[i] = 8'h7F; end
    drive_vec(4, 8'h00, 0, zv, z);
    n_checks++;
    if (z !== 8'h7F) begin
      n_fail++;
      $display("FAIL sat_pos: z_value=%h want 7f", z);
    end
    release_z(0);
    for (int i = 0; i < 4; i++) begin vx[i] = 8'h80; vw[i] = 8'h7F; end
    drive_vec(4, 8'h00, 0, zv, z);
    n_checks++;
    if (z !== 8'h80) begin
      n_fail++;
      $display("FAIL sat_neg: z_value=%h want 80", z);
    end
    release_z(0);
    for (int i = 0; i < 40; i++) begin vx[i] = 8'h7F; vw[i] = 8'h7F; end
    drive_vec(40, 8'h00, 0, zv, z);
    n_checks++;
    if (z !== 8'h7F) begin
      n_fail++;
      $display("FAIL sat_acc: z_value=%h want 7f", z);
    end
    release_z(0);
  endtask

  task automatic test_backpressure();
    logic zv;
    logic [7:0] z0;
    logic [7:0] z;
    logic [7:0] b;
    vx[0] = 8'h23; vw[0] = 8'hE1; vx[1] = 8'h35; vw[1] = 8'h11;
    drive_vec(2, 8'h15, 0, zv, z0);
    n_checks++;
    if (zv !== 1'b1 || z0 !== model_z(2, 8'h15)) begin
      n_fail++;
      $display("FAIL bp_result: z_valid=%b z_value=%h want 1/%h", zv, z0, model_z(2, 8'h15));
    end
    // Offer junk beats while the result is held; none may be consumed.
    for (int c = 0; c < 5; c++) begin
      bus_if.in_valid = 1'b1; bus_if.x = 8'h7F; bus_if.w = 8'h7F;
      bus_if.bias = 8'h7F; bus_if.in_last = 1'b1; bus_if.z_ready = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (bus_if.z_valid !== 1'b1 || bus_if.z_value !== z0 || bus_if.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: z_valid=%b z_value=%h in_ready=%b want 1/%h/0",
                 c, bus_if.z_valid, bus_if.z_value, bus_if.in_ready, z0);
      end
    end
    bus_if.z_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.z_ready  = 1'b0;
    bus_if.in_valid = 1'b0;
    n_checks++;
    if (bus_if.in_ready !== 1'b1 || bus_if.z_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: in_ready=%b z_valid=%b want 1/0", bus_if.in_ready, bus_if.z_valid);
    end
    b = 8'hE0;
    vx[0] = 8'h18; vw[0] = 8'h20;
    drive_vec(1, b, 0, zv, z);
    n_checks++;
    if (zv !== 1'b1 || z !== model_z(1, b)) begin
      n_fail++;
      $display("FAIL bp_next: z_value=%h want %h", z, model_z(1, b));
    end
    release_z(0);
  endtask

  task automatic test_stalls();
    logic zv1, zv2;
    logic [7:0] z1, z2, b;
    for (int t = 0; t < 4; t++) begin
      b = 8'($urandom);
      for (int i = 0; i < 3; i++) begin vx[i] = 8'($urandom); vw[i] = 8'($urandom); end
      drive_vec(3, b, 0, zv1, z1);
      release_z(0);
      drive_vec(3, b, 60, zv2, z2);
      release_z(2);
      n_checks++;
      if (zv1 !== 1'b1 || zv2 !== 1'b1 || z1 !== model_z(3, b) || z2 !== z1) begin
        n_fail++;
        $display("FAIL stalls[%0d]: gapfree=%h gapped=%h want %h", t, z1, z2, model_z(3, b));
      end
    end
  endtask

  task automatic test_random();
    logic zv;
    logic [7:0] z, b;
    int n;
    for (int t = 0; t < 25; t++) begin
      n = int'($urandom_range(1, 8));
      b = 8'($urandom);
      for (int i = 0; i < n; i++) begin vx[i] = 8'($urandom); vw[i] = 8'($urandom); end
      drive_vec(n, b, 30, zv, z);
      n_checks++;
      if (zv !== 1'b1 || z !== model_z(n, b)) begin
        n_fail++;
        $display("FAIL random[%0d] n=%0d: z_valid=%b z_value=%h want 1/%h", t, n, zv, z, model_z(n, b));
      end
      release_z(int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    rst             = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.x        = '0;
    bus_if.w        = '0;
    bus_if.bias     = '0;
    bus_if.in_last  = 1'b0;
    bus_if.z_ready  = 1'b0;
    #12;
    test_reset();
    test_basic();
    test_truncation();
    test_saturation();
    test_backpressure();
    test_stalls();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lstm_neuron_mac.md
# lstm_neuron_mac

Per-neuron multiply-accumulate stage that feeds the sigmoid/tanh activation (LUT + linear interpolator) in the LSTM datapath. It consumes a serial stream of signed Q4.4 input/weight pairs for one neuron, accumulates the products at full precision, adds a Q4.4 bias, and requantizes the sum to the signed 8-bit Q4.4 `z_value` that the activation stage expects. Input and output use valid/ready handshakes so the stage can stall on either side.

## Interface
Parameters:
- DATA_W, 8, width of x, w, bias and z_value (signed two's complement)
- FRAC_W, 4, fractional bits of x, w, bias and z_value (Q4.4)
- ACC_W, 20, accumulator width (signed, Q(ACC_W-2*FRAC_W).(2*FRAC_W))

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  x/w/bias/in_last valid
- in_ready  out  1  stage accepts a pair this cycle
- x  in  DATA_W  signed input sample, Q4.4
- w  in  DATA_W  signed weight, Q4.4
- bias  in  DATA_W  signed bias, Q4.4; sampled only on the first beat of a vector
- in_last  in  1  marks final pair of the vector
- z_valid  out  1  z_value holds a completed result
- z_ready  in  1  activation stage accepts z_value
- z_value  out  DATA_W  signed pre-activation, Q4.4, to activation input

## Operation
- States: ACC (accepting pairs) and OUT (holding result). Reset state ACC.
- in_ready = 1 in ACC, 0 in OUT. Beat accepted when in_valid && in_ready.
- Internal flag `first` = 1 after reset and after each output handshake; cleared by any accepted beat.
- Accepted beat: p = x*w (2*DATA_W signed, Q8.8). If first: sum = (bias sign-extended << FRAC_W) + p; else sum = acc + p. sum saturates to ACC_W signed range; result stored in acc.
- Accepted beat with in_last=1: state -> OUT; z_value register <= quantize(sum); z_valid <= 1; acc cleared.
- quantize: arithmetic shift right by FRAC_W (floor, no rounding), then saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1] (0x80..0x7F).
- OUT: z_value and z_valid held stable while z_ready=0. On z_valid && z_ready: z_valid <= 0, state -> ACC, first <= 1.
- Single-beat vector (first and in_last together) is legal: z = quantize(bias<<FRAC_W + x*w).
- in_valid=0 in ACC: acc, first unchanged (pause mid-vector allowed).
- Inputs other than in_valid ignored when not accepted; bias ignored on non-first beats.

## Timing
- Reset (rst=0, asynchronous): state ACC, acc=0, first=1, z_valid=0, z_value=0; in_ready=1 once rst released. Reset mid-vector or while holding a result discards it; no output produced.
- One beat per cycle in ACC; no internal stall.
- Latency: last beat accepted on edge t -> z_valid=1 and z_value valid after edge t (same register update).
- Output handshake on edge t+k -> in_ready=1 after that edge; next vector's first beat accepted at earliest edge t+k+1. Minimum period N+1 cycles for an N-pair vector.
- in_ready is a function of registered state only (no combinational path from z_ready).

## Test plan
- Reset: assert rst=0 mid-vector after 2 beats -> z_valid=0, z_value=0x00, in_ready=1; new vector x=0x10,w=0x10,bias=0x00,last -> z_value=0x10.
- Basic: pairs (0x10,0x20),(0x10,0x10), bias=0x08, last on 2nd -> z_value=0x38 (0.5+2.0+1.0=3.5), z_valid 1 cycle after last beat.
- Truncation/negative: single beat x=0xF8 (-0.5), w=0x18 (1.5), bias=0x00 -> product -192, >>4 = -12 -> z_value=0xF4; x=0x01,w=0x01 -> 0x00.
- Saturation: 4 beats x=0x7F,w=0x7F -> z_value=0x7F; 4 beats x=0x80,w=0x7F -> z_value=0x80; accumulator saturation with 40 beats x=w=0x7F -> z_value=0x7F, no wrap.
- Backpressure: hold z_ready=0 for 5 cycles with in_valid=1 -> z_value stable, in_ready=0, no beats consumed; z_ready=1 -> in_ready=1 next cycle, next vector result correct and independent (bias re-sampled).
- Input stalls: random in_valid gaps within a 3-beat vector -> same z_value as gap-free run.
